// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - shared op codes, reset PC and state encoding for the fetch sequencer
package fetch_seq_pkg;

    // Next-PC operation decoded from the instruction in D
    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;
    localparam logic [1:0] NPC_JR  = 2'b11;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // S_FETCH: request outstanding to imem
    // S_HOLD : a completed word is parked in buf while D is stalled
    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_seq_if.sv
// rtl/fetch_seq_if.sv - instruction-memory read handshake between fetch_seq and imem
//  imem_req   : fetch -> imem, read request; imem_addr stable while req & !ready
//  imem_addr  : fetch -> imem, read address
//  imem_ready : imem -> fetch, read completes this cycle
//  imem_rdata : imem -> fetch, instruction word, valid with imem_ready
interface fetch_seq_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_seq_npc_target.sv
// rtl/fetch_seq_npc_target.sv - combinational control-transfer target calculator
//  npc_op   : in  2  NPC_BR / NPC_J / NPC_JR select (NPC_SEQ gives pc_d+4, unused)
//  pc_d     : in  32 PC of the instruction in D
//  imm16    : in  16 branch offset (words, sign-extended)
//  imm26    : in  26 jump index
//  reg_addr : in  32 forwarded rs for jr
//  target   : out 32 transfer target
module npc_target
    import fetch_seq_pkg::*;
(
    input  logic [1:0]  npc_op,
    input  logic [31:0] pc_d,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] reg_addr,
    output logic [31:0] target
);

    logic [31:0] pc4;
    logic [31:0] br_off;

    assign pc4    = pc_d + 32'd4;
    assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        target = pc4;
        unique case (npc_op)
            NPC_BR:  target = pc4 + br_off;
            NPC_J:   target = {pc_d[31:28], imm26, 2'b00};
            NPC_JR:  target = reg_addr;
            default: target = pc4;
        endcase
    end

endmodule

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - MIPS fetch-stage sequencer: PC_F, imem handshake, F/D register, delay-slot redirects
//  clk, reset  : clock and synchronous active-high reset
//  stall_i     : hold D this cycle
//  npc_op_d    : next-PC op of instr_d; imm16_d / imm26_d / reg_addr_d its operands
//  imem        : fetch_seq_if.master read handshake
//  pc_f        : address of next instruction to enter D
//  instr_d, pc_d, pc8_d, valid_d : F/D register and link value
module fetch_seq
    import fetch_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic [1:0]         npc_op_d,
    input  logic [15:0]        imm16_d,
    input  logic [25:0]        imm26_d,
    input  logic [31:0]        reg_addr_d,
    fetch_seq_if.master        imem,
    output logic [31:0]        pc_f,
    output logic [31:0]        instr_d,
    output logic [31:0]        pc_d,
    output logic [31:0]        pc8_d,
    output logic               valid_d
);

    fetch_state_t state, state_next;

    logic [31:0] word_buf;
    logic        pending;
    logic [31:0] pend_tgt;

    logic        avail;
    logic [31:0] word;
    logic        adv;
    logic        consume;
    logic        redirect;
    logic [31:0] target;

    npc_target u_npc_target (
        .npc_op   (npc_op_d),
        .pc_d     (pc_d),
        .imm16    (imm16_d),
        .imm26    (imm26_d),
        .reg_addr (reg_addr_d),
        .target   (target)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            S_FETCH: if (imem.imem_ready && stall_i) state_next = S_HOLD;
            S_HOLD:  if (!stall_i)                   state_next = S_FETCH;
            default: state_next = S_FETCH;
        endcase
    end

    // Output logic: request, word availability and word source
    always_comb begin
        imem.imem_req = 1'b0;
        avail         = 1'b0;
        word          = imem.imem_rdata;
        unique case (state)
            S_FETCH: begin
                imem.imem_req = !reset;
                avail         = imem.imem_ready && !reset;
            end
            S_HOLD: begin
                avail = 1'b1;
                word  = word_buf;
            end
            default: ;
        endcase
    end

    assign imem.imem_addr = pc_f;

    assign adv      = !stall_i;
    assign consume  = adv && avail;
    // A bubble in D carries no control transfer, whatever npc_op_d says
    assign redirect = adv && valid_d && (npc_op_d != NPC_SEQ);

    assign pc8_d = pc_d + 32'd8;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_f     <= RESET_PC;
            instr_d  <= 32'd0;
            pc_d     <= 32'd0;
            valid_d  <= 1'b0;
            pending  <= 1'b0;
            pend_tgt <= 32'd0;
            word_buf <= 32'd0;
        end else begin
            if (adv) begin
                if (avail) begin
                    instr_d <= word;
                    pc_d    <= pc_f;
                    valid_d <= 1'b1;
                end else begin
                    valid_d <= 1'b0;
                end
            end

            if (consume) begin
                if (redirect) begin
                    pc_f <= target;
                end else if (pending) begin
                    pc_f <= pend_tgt;
                end else begin
                    pc_f <= pc_f + 32'd4;
                end
                pending <= 1'b0;
            end else if (redirect) begin
                // Delay slot still outstanding: remember where to go once it lands
                pending  <= 1'b1;
                pend_tgt <= target;
            end

            if (state == S_FETCH && imem.imem_ready && stall_i) begin
                word_buf <= imem.imem_rdata;
            end
        end
    end

endmodule
